// File: rtl/ram_io_responder.sv
// Memory-side end of the CPU byte bus: byte RAM, TX/RX FIFOs, program-stop flag and cycle counter.
// Build macro IO_CYCLE_COUNTER_EN adds the cycle counter readable at 0x30004..0x30007.
module ram_io_responder #(
    parameter int ADDR_W       = 17,
    parameter int TX_DEPTH     = 16,
    parameter int RX_DEPTH     = 16,
    parameter int AFULL_MARGIN = 2
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [31:0] cpu_addr,
    input  logic        cpu_wr,
    input  logic [7:0]  cpu_wdata,
    output logic [7:0]  cpu_rdata,
    output logic        io_buffer_full,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ready,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    output logic        prog_stop,
    output logic        tx_overflow
);
    localparam int TXP_W = $clog2(TX_DEPTH);
    localparam int RXP_W = $clog2(RX_DEPTH);
    localparam logic [TXP_W:0] TX_FULL  = (TXP_W + 1)'(TX_DEPTH);
    localparam logic [TXP_W:0] TX_AFULL = (TXP_W + 1)'(TX_DEPTH - AFULL_MARGIN);
    localparam logic [RXP_W:0] RX_FULL  = (RXP_W + 1)'(RX_DEPTH);

    logic [7:0] ram    [2**ADDR_W];
    logic [7:0] tx_mem [TX_DEPTH];
    logic [7:0] rx_mem [RX_DEPTH];

    logic [TXP_W-1:0] tx_wr_ptr_q, tx_rd_ptr_q;
    logic [TXP_W:0]   tx_count_q, tx_count_d;
    logic [RXP_W-1:0] rx_wr_ptr_q, rx_rd_ptr_q;
    logic [RXP_W:0]   rx_count_q, rx_count_d;
    logic             prog_stop_q, tx_overflow_q, io_buffer_full_q, rd_is_ram_q;
    logic [7:0]       io_rdata_q, io_rdata_d, ram_rdata_q;

    logic is_io, io_data, io_ctrl, cpu_rd, wr_en, ram_we, stop_wr;
    logic tx_push_req, tx_push, tx_pop, tx_full, tx_drop, rx_push, rx_pop, rx_nonempty;
    logic [7:0] tx_push_byte;
    logic [ADDR_W-1:0] ram_a;
    logic unused_addr_bits;

    assign is_io   = cpu_addr[17:16] == 2'b11;
    assign io_data = is_io && cpu_addr[15:0] == 16'h0000;
    assign io_ctrl = is_io && cpu_addr[15:2] == 14'h0001;
    assign cpu_rd  = !cpu_wr;
    assign wr_en   = cpu_wr && !prog_stop_q;
    assign ram_we  = wr_en && !is_io;
    assign stop_wr = wr_en && io_ctrl && cpu_addr[1:0] == 2'b00;
    assign ram_a   = cpu_addr[ADDR_W-1:0];
    assign unused_addr_bits = ^cpu_addr[31:18];

    // The stop write queues a 0x00 terminator; a plain 0x00 data write is dropped.
    assign tx_push_req  = (wr_en && io_data && cpu_wdata != 8'h00) || stop_wr;
    assign tx_push_byte = stop_wr ? 8'h00 : cpu_wdata;
    assign tx_valid     = tx_count_q != '0;
    assign tx_pop       = tx_valid && tx_ready;
    assign tx_full      = tx_count_q == TX_FULL;
    assign tx_push      = tx_push_req && (!tx_full || tx_pop);
    assign tx_drop      = tx_push_req && tx_full && !tx_pop;
    assign tx_count_d   = tx_count_q + {TXP_W'(0), tx_push} - {TXP_W'(0), tx_pop};
    assign tx_data      = tx_mem[tx_rd_ptr_q];

    assign rx_ready    = rx_count_q != RX_FULL;
    assign rx_nonempty = rx_count_q != '0;
    assign rx_push     = rx_valid && rx_ready;
    assign rx_pop      = cpu_rd && io_data && rx_nonempty;
    assign rx_count_d  = rx_count_q + {RXP_W'(0), rx_push} - {RXP_W'(0), rx_pop};

`ifdef IO_CYCLE_COUNTER_EN
    logic [31:0] cycle_q;
    logic [23:0] snap_hi_q;

    // Byte 0 comes from the live count; the read also freezes the upper bytes for 0x30005..7.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            cycle_q   <= '0;
            snap_hi_q <= '0;
        end else begin
            cycle_q <= cycle_q + 32'd1;
            if (cpu_rd && io_ctrl && cpu_addr[1:0] == 2'b00)
                snap_hi_q <= cycle_q[31:8];
        end
    end
`endif

    // NOTE: every signal assigned in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        io_rdata_d = 8'h00;
        if (io_data && rx_nonempty)
            io_rdata_d = rx_mem[rx_rd_ptr_q];
`ifdef IO_CYCLE_COUNTER_EN
        else if (io_ctrl) begin
            case (cpu_addr[1:0])
                2'd0:    io_rdata_d = cycle_q[7:0];
                2'd1:    io_rdata_d = snap_hi_q[7:0];
                2'd2:    io_rdata_d = snap_hi_q[15:8];
                default: io_rdata_d = snap_hi_q[23:16];
            endcase
        end
`endif
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            tx_wr_ptr_q      <= '0;
            tx_rd_ptr_q      <= '0;
            tx_count_q       <= '0;
            rx_wr_ptr_q      <= '0;
            rx_rd_ptr_q      <= '0;
            rx_count_q       <= '0;
            prog_stop_q      <= 1'b0;
            tx_overflow_q    <= 1'b0;
            io_buffer_full_q <= 1'b0;
            rd_is_ram_q      <= 1'b0;
            io_rdata_q       <= 8'h00;
        end else begin
            if (tx_push) tx_wr_ptr_q <= tx_wr_ptr_q + TXP_W'(1);
            if (tx_pop)  tx_rd_ptr_q <= tx_rd_ptr_q + TXP_W'(1);
            if (rx_push) rx_wr_ptr_q <= rx_wr_ptr_q + RXP_W'(1);
            if (rx_pop)  rx_rd_ptr_q <= rx_rd_ptr_q + RXP_W'(1);
            tx_count_q       <= tx_count_d;
            rx_count_q       <= rx_count_d;
            io_buffer_full_q <= tx_count_d >= TX_AFULL;
            if (tx_drop) tx_overflow_q <= 1'b1;
            if (stop_wr) prog_stop_q <= 1'b1;
            if (cpu_rd) begin
                rd_is_ram_q <= !is_io;
                io_rdata_q  <= io_rdata_d;
            end
        end
    end

    // NOTE: storage arrays are not reset; FIFO contents are invalidated by the pointer/count reset instead.
    always_ff @(posedge clk_in) begin
        if (ram_we)              ram[ram_a] <= cpu_wdata;
        if (cpu_rd && !is_io)    ram_rdata_q <= ram[ram_a];
        if (tx_push)             tx_mem[tx_wr_ptr_q] <= tx_push_byte;
        if (rx_push)             rx_mem[rx_wr_ptr_q] <= rx_data;
    end

    assign cpu_rdata      = rd_is_ram_q ? ram_rdata_q : io_rdata_q;
    assign io_buffer_full = io_buffer_full_q;
    assign prog_stop      = prog_stop_q;
    assign tx_overflow    = tx_overflow_q;
endmodule
